rv_branch_predictor: RTL and testbench
======================================

// Module: rv_branch_predictor
// PURPOSE
//  Fetch-side counterpart of the execute-stage branch comparator. Predicts branch
//  direction and target for the fetch PC, then learns from the taken/not-taken
//  results the comparator resolves in execute.
//  Direct-mapped table: per entry a valid bit, PC tag, target and a 2-bit saturating counter.
//  Sits between the PC generator (lookup) and the execute-stage resolution (update).
// PARAMETERS
//  ENTRIES  16                   table depth; power of two, >= 2
//  INDEX_W  $clog2(ENTRIES)      index width; derived, do not override
//  TAG_W    BUS_W-INDEX_W-2      tag width; derived, PC[1:0] not stored
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  bpReady      out  1       table initialised; lookups/updates accepted
//  predValid    in   1       lookup request this cycle
//  predPC       in   BUS_W   PC to predict
//  predRespValid out 1       response valid (1 cycle after accepted predValid)
//  predHit      out  1       tag hit in table
//  predTaken    out  1       predicted taken
//  predTarget   out  BUS_W   predicted next PC
//  updValid     in   1       resolved branch from execute
//  updPC        in   BUS_W   PC of the resolved branch
//  updTaken     in   1       resolved direction (comparator result)
//  updTarget    in   BUS_W   resolved taken target
// BEHAVIOUR
//  - Index = PC[INDEX_W+1:2]; tag = PC[BUS_W-1:INDEX_W+2].
//  - Counters: SNT=00, WNT=01, WT=10, ST=11; taken when ctr[1]=1.
//  - FSM CLEAR -> RUN.
//    - rst (any state, any cycle) -> CLEAR with clear index 0.
//    - CLEAR: 1 entry/cycle, valid=0, ctr=WNT; leaves for RUN after entry ENTRIES-1,
//      so bpReady rises exactly ENTRIES cycles after rst is released.
//    - Mid-clear rst restarts the clear at index 0.
//  - Reset values: bpReady=0, predRespValid=0, predHit=0, predTaken=0, predTarget=0.
//  - In CLEAR: predValid and updValid are ignored; predRespValid stays 0.
//  - Lookup, RUN only: predValid at edge N -> response registered at edge N+1.
//    - predRespValid=1 for exactly one cycle per request; back-to-back requests allowed.
//    - hit = valid && tag match.
//    - predTaken = hit & ctr[1].
//    - predTarget = stored target if predTaken, else predPC+4 (mod 2^BUS_W, wraps).
//    - When no response is valid, the outputs hold their last values.
//  - Update (RUN, updValid), applied at that edge:
//    - hit: ctr saturating +1 if updTaken else -1 (11 stays 11, 00 stays 00);
//      target overwritten with updTarget if updTaken.
//    - miss and updTaken: allocate/replace entry: valid=1, tag, target=updTarget, ctr=WT.
//    - miss and not updTaken: no table change.
//  - Lookup and update to the same index in the same cycle: the lookup returns the pre-update
//    (read-before-write) state. The next lookup sees the updated state.
//  - No backpressure; the predictor never stalls the requester once bpReady=1.
// STRUCTURE
//  - Shared include/package, next to BUS_W: counter encodings (SNT/WNT/WT/ST) and
//    FSM state encodings (BP_CLEAR, BP_RUN).
//  - Sub-module rv_sat_ctr2: 2-bit saturating inc/dec, combinational; instanced on the
//    update path.
//  - Table held as flat reg arrays (valid, tag, target, ctr); no vendor RAM macro.
// TESTING
//  1. rst for 1 cycle -> bpReady=0 for 16 cycles, then 1; lookup PC 0x100 ->
//     predHit=0, predTaken=0, predTarget=0x104.
//  2. Update PC 0x100, taken, target 0x200 -> lookup 0x100 -> hit=1, taken=1, target=0x200.
//  3. Continue from 2, update 0x100 not taken -> ctr WNT, predTaken=0, target=0x104.
//     Second not-taken -> SNT; two more not-taken -> stays SNT.
//  4. Alias: 0x140 (index 0, other tag) -> miss. Taken update 0x140 -> 0x300
//     replaces the entry; lookup 0x100 now misses.
//  5. Lookup 0x100 and taken update 0x100 in the same cycle -> response shows the old
//     state; next lookup shows the new state. 4 taken updates saturate at ST.
//  6. rst asserted at clear index 7 -> bpReady stays 0 for 16 more cycles; all
//     previously learned entries miss.

Source files
------------

// File: rtl/rv_branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: bus width, counter encodings, FSM states.
// Counter encodings follow the usual 2-bit bimodal scheme; bit 1 is the taken prediction.
package rv_branch_predictor_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        BP_CLEAR = 1'b0,
        BP_RUN   = 1'b1
    } bp_state_e;

endpackage

// File: rtl/rv_sat_ctr2.sv
// 2-bit saturating up/down counter step, purely combinational.
// Used on the predictor update path to train the direction counter.
module rv_sat_ctr2
    import rv_branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/rv_branch_predictor.sv
// Direct-mapped branch predictor: 1-cycle registered lookup, same-edge update from execute.
// Table is swept clear one entry per cycle after reset; no backpressure once bpReady is high.
module rv_branch_predictor
    import rv_branch_predictor_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int INDEX_W = $clog2(ENTRIES),
    localparam int TAG_W   = BUS_W - INDEX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             bpReady,
    input  logic             predValid,
    input  logic [BUS_W-1:0] predPC,
    output logic             predRespValid,
    output logic             predHit,
    output logic             predTaken,
    output logic [BUS_W-1:0] predTarget,
    input  logic             updValid,
    input  logic [BUS_W-1:0] updPC,
    input  logic             updTaken,
    input  logic [BUS_W-1:0] updTarget
);

    bp_state_e            state, state_nxt;
    logic [INDEX_W-1:0]   clr_idx, clr_idx_nxt;

    logic [ENTRIES-1:0]   tbl_valid;
    logic [TAG_W-1:0]     tbl_tag    [ENTRIES];
    logic [BUS_W-1:0]     tbl_target [ENTRIES];
    logic [1:0]           tbl_ctr    [ENTRIES];

    logic                 run;
    logic [INDEX_W-1:0]   look_idx, upd_idx;
    logic [TAG_W-1:0]     look_tag, upd_tag;
    logic                 look_hit, look_taken, upd_hit;
    logic [1:0]           upd_ctr_nxt;
    logic                 unused_pc_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BP_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            BP_CLEAR: begin
                clr_idx_nxt = clr_idx + 1'b1;
                if (clr_idx == INDEX_W'(ENTRIES - 1)) state_nxt = BP_RUN;
            end
            BP_RUN:  state_nxt = BP_RUN;
            default: state_nxt = BP_CLEAR;
        endcase
    end

    assign run     = (state == BP_RUN);
    assign bpReady = run;

    assign look_idx   = predPC[INDEX_W+1:2];
    assign look_tag   = predPC[BUS_W-1:INDEX_W+2];
    assign look_hit   = tbl_valid[look_idx] && (tbl_tag[look_idx] == look_tag);
    assign look_taken = look_hit && tbl_ctr[look_idx][1];

    assign upd_idx = updPC[INDEX_W+1:2];
    assign upd_tag = updPC[BUS_W-1:INDEX_W+2];
    assign upd_hit = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);

    // Byte offset within the instruction word never selects an entry.
    assign unused_pc_bits = ^{predPC[1:0], updPC[1:0]};

    rv_sat_ctr2 u_sat_ctr (
        .ctr      (tbl_ctr[upd_idx]),
        .inc      (updTaken),
        .ctr_next (upd_ctr_nxt)
    );

    // Only valid/ctr are swept; tag and target are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == BP_CLEAR) begin
                tbl_valid[clr_idx] <= 1'b0;
                tbl_ctr[clr_idx]   <= CTR_WNT;
            end else if (updValid) begin
                if (upd_hit) begin
                    tbl_ctr[upd_idx] <= upd_ctr_nxt;
                    if (updTaken) tbl_target[upd_idx] <= updTarget;
                end else if (updTaken) begin
                    tbl_valid[upd_idx]  <= 1'b1;
                    tbl_tag[upd_idx]    <= upd_tag;
                    tbl_target[upd_idx] <= updTarget;
                    tbl_ctr[upd_idx]    <= CTR_WT;
                end
            end
        end
    end

    // Lookup reads the table before this edge's update lands (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            predRespValid <= 1'b0;
            predHit       <= 1'b0;
            predTaken     <= 1'b0;
            predTarget    <= '0;
        end else begin
            predRespValid <= run && predValid;
            if (run && predValid) begin
                predHit    <= look_hit;
                predTaken  <= look_taken;
                predTarget <= look_taken ? tbl_target[look_idx] : predPC + BUS_W'(4);
            end
        end
    end

endmodule

// File: tb/tb_rv_branch_predictor.sv
// Directed plus randomized bench for rv_branch_predictor against an entry-level table model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_rv_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        bpReady;
    logic        predValid;
    logic [31:0] predPC;
    logic        predRespValid;
    logic        predHit;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        updValid;
    logic [31:0] updPC;
    logic        updTaken;
    logic [31:0] updTarget;

    int checks   = 0;
    int failures = 0;

    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    logic        last_hit, last_taken;
    logic [31:0] last_target;

    always #5 clk = ~clk;

    rv_branch_predictor #(.ENTRIES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bpReady       (bpReady),
        .predValid     (predValid),
        .predPC        (predPC),
        .predRespValid (predRespValid),
        .predHit       (predHit),
        .predTaken     (predTaken),
        .predTarget    (predTarget),
        .updValid      (updValid),
        .updPC         (updPC),
        .updTaken      (updTaken),
        .updTarget     (updTarget)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        last_hit = 0; last_taken = 0; last_target = 0;
    endtask

    task automatic idle_inputs();
        predValid = 0; predPC = 0;
        updValid = 0; updPC = 0; updTaken = 0; updTarget = 0;
    endtask

    // One RUN-state cycle: optional lookup and optional update, then check response.
    task automatic cycle(input bit pv, input logic [31:0] ppc,
                         input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input string tag);
        int  li, ui;
        bit  hit, uhit;
        predValid = pv; predPC = ppc;
        updValid = uv; updPC = upc; updTaken = ut; updTarget = utgt;
        if (pv) begin
            li = int'(ppc[5:2]);
            hit = m_valid[li] && (m_tag[li] == ppc[31:6]);
            last_hit    = hit;
            last_taken  = hit && (m_ctr[li] >= 2);
            last_target = last_taken ? m_tgt[li] : ppc + 32'd4;
        end
        if (uv) begin
            ui = int'(upc[5:2]);
            uhit = m_valid[ui] && (m_tag[ui] == upc[31:6]);
            if (uhit) begin
                m_ctr[ui] = ut ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                               : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
                if (ut) m_tgt[ui] = utgt;
            end else if (ut) begin
                m_valid[ui] = 1; m_tag[ui] = upc[31:6]; m_tgt[ui] = utgt; m_ctr[ui] = 2;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        chk({tag, ".vld"},    {31'd0, predRespValid}, {31'd0, pv});
        chk({tag, ".hit"},    {31'd0, predHit},       {31'd0, last_hit});
        chk({tag, ".taken"},  {31'd0, predTaken},     {31'd0, last_taken});
        chk({tag, ".target"}, predTarget,             last_target);
    endtask

    task automatic look(input logic [31:0] pc, input string tag);
        cycle(1, pc, 0, 0, 0, 0, tag);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input string tag);
        cycle(0, 0, 1, pc, t, tgt, tag);
    endtask

    // Runs the clear sweep with junk traffic; bpReady must rise on the 16th edge only.
    task automatic clear_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            predValid = 1; predPC = 32'h100;
            updValid = 1; updPC = 32'h100; updTaken = 1; updTarget = 32'h999;
            @(posedge clk); #1;
            chk($sformatf("%s.ready%0d", tag, i), {31'd0, bpReady}, {31'd0, (i == 15)});
            chk($sformatf("%s.rvld%0d", tag, i), {31'd0, predRespValid}, 32'd0);
        end
        idle_inputs();
    endtask

    logic [25:0] tag_pool [4];

    initial begin
        tag_pool[0] = 26'h4; tag_pool[1] = 26'h5; tag_pool[2] = 26'h3FFFFFF; tag_pool[3] = 26'h0;
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_clear();
        chk("rst.ready",  {31'd0, bpReady},       32'd0);
        chk("rst.rvld",   {31'd0, predRespValid}, 32'd0);
        chk("rst.hit",    {31'd0, predHit},       32'd0);
        chk("rst.taken",  {31'd0, predTaken},     32'd0);
        chk("rst.target", predTarget,             32'd0);
        rst = 0;
        clear_sweep("clr1");

        look(32'h100, "t1");
        upd(32'h100, 1, 32'h200, "t2u");
        look(32'h100, "t2");
        chk("t2.taken_const", {31'd0, predTaken}, 32'd1);
        chk("t2.target_const", predTarget, 32'h200);
        upd(32'h100, 0, 0, "t3u1");
        look(32'h100, "t3a");
        chk("t3a.target_const", predTarget, 32'h104);
        for (int i = 0; i < 3; i++) upd(32'h100, 0, 0, "t3u");
        look(32'h100, "t3b");
        upd(32'h100, 1, 32'h220, "t3u5");
        look(32'h100, "t3c");
        chk("t3c.taken_const", {31'd0, predTaken}, 32'd0);

        look(32'h140, "t4a");
        upd(32'h140, 1, 32'h300, "t4u");
        look(32'h140, "t4b");
        look(32'h100, "t4c");
        chk("t4c.hit_const", {31'd0, predHit}, 32'd0);

        upd(32'h100, 1, 32'h400, "t5a");
        cycle(1, 32'h100, 1, 32'h100, 1, 32'h480, "t5same");
        look(32'h100, "t5after");
        for (int i = 0; i < 4; i++) upd(32'h100, 1, 32'h500, "t5sat");
        upd(32'h100, 0, 0, "t5dn");
        look(32'h100, "t5chk");
        look(32'hFFFF_FFFC, "wrap");
        chk("wrap.target_const", predTarget, 32'h0);

        cycle(1, 32'h100, 0, 0, 0, 0, "b2b1");
        cycle(1, 32'h140, 0, 0, 0, 0, "b2b2");
        cycle(0, 0, 0, 0, 0, 0, "hold");

        for (int n = 0; n < 400; n++) begin
            logic [31:0] pa, pb;
            pa = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            pb = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 3) == 0) pb = pa;
            cycle(1'($urandom_range(0, 1)), pa, 1'($urandom_range(0, 1)), pb,
                  1'($urandom_range(0, 1)), $urandom, "rnd");
        end

        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mid.ready%0d", i), {31'd0, bpReady}, 32'd0);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_clear();
        clear_sweep("clr2");
        look(32'h100, "t6a");
        look(32'h140, "t6b");
        for (int i = 0; i < 16; i++) look({26'h5, 4'(i), 2'b00}, "t6sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
